shift_arbiter: RTL and testbench
================================

# shift_arbiter

Shares the single combinational right-shift datapath (SRL function code 6'b000010, shift amount taken from operand B bits [4:0]) between two requesters: the EX-stage ALU path and the multi-cycle multiply/divide unit. It runs a round-robin valid/ready arbiter and drives the shifter's operand and function inputs. Each result is captured into a per-requester response register, which holds it until the requester accepts it. Throughput is one shift per cycle across both requesters, and each result appears one cycle after its request is accepted.

## Interface
Parameters:
- WIDTH, 32, data width; must match the shift datapath.
- SRL_CODE, 6'b000010, function code that makes the shifter output the shifted value.
- IDLE_CODE, 6'b000000, function code driven when no request is granted.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- r0_valid  in  1  requester 0 (EX stage) has a shift request.
- r0_ready  out  1  request 0 accepted this cycle.
- r0_data  in  WIDTH  value to shift.
- r0_shamt  in  5  shift amount, 0..31.
- r0_resp_valid  out  1  result register 0 holds a result.
- r0_resp_ready  in  1  requester 0 consumes the result this cycle.
- r0_resp_data  out  WIDTH  result 0.
- r1_valid, r1_ready, r1_data, r1_shamt, r1_resp_valid, r1_resp_ready, r1_resp_data: identical set for requester 1 (mul/div unit).
- sh_dataA  out  WIDTH  shifter operand A.
- sh_dataB  out  WIDTH  shifter operand B, {27'b0, shamt}.
- sh_signal  out  6  shifter function code.
- sh_dataOut  in  WIDTH  shifter result (combinational, same cycle).
- grant  out  2  one-hot grant this cycle; 2'b00 when idle.

## Operation
- Slot i is free when ri_resp_valid==0, or when ri_resp_valid==1 and ri_resp_ready==1 (drain and refill in the same cycle).
- Requester i is eligible when ri_valid==1 and slot i is free.
- Arbitration:
  - At most one grant per cycle.
  - If both requesters are eligible, the one selected by the round-robin pointer `prio` wins.
  - If only one is eligible, it wins regardless of `prio`.
  - After every grant to i, `prio` moves to the other requester. `prio` is unchanged when there is no grant.
- ri_ready = grant[i]. It is combinational from ri_valid, ri_resp_valid and ri_resp_ready. There is no combinational path from sh_dataOut to any ready.
- Shifter drive:
  - When granted: sh_dataA = granted data, sh_dataB = {27'b0, granted shamt}, sh_signal = SRL_CODE.
  - When idle: sh_dataA = 0, sh_dataB = 0, sh_signal = IDLE_CODE.
- Capture on a grant to i: ri_resp_data <= sh_dataOut and ri_resp_valid <= 1.
- Drain without refill: ri_resp_valid <= 0 and ri_resp_data holds its value.
- A request that is not granted must keep ri_valid, ri_data and ri_shamt stable until ri_ready is high. The block does not latch unaccepted requests.
- Shift semantics are logical right shift with zero fill. shamt=0 returns the data unchanged.

## Timing
- Reset (rst_n low, asynchronous):
  - r0_resp_valid = r1_resp_valid = 0.
  - r0_resp_data = r1_resp_data = 0.
  - `prio` = requester 0.
  - grant = 00, so sh_signal = IDLE_CODE.
  - Any in-flight grant is discarded.
- Latency: a request accepted at edge N has its response valid from edge N+1.
- Back-to-back: one requester with resp_ready held high gets a grant every cycle when it is the only active requester. With both requesters active and both draining, grants alternate 0,1,0,1.
- Full slot with resp_ready low: that requester gets no grant and the other requester may be granted in the same cycle. That grant does not advance `prio` toward the blocked requester beyond the normal rule.
- Simultaneous drain and grant on the same slot: the new result replaces the old one and resp_valid stays 1. No bubble.
- Reset deassertion: the first grant is possible in the first cycle after rst_n rises.

## Test plan
- Single request: r0 data=32'hF000_000F, shamt=4 -> r0_ready=1 in the same cycle; next cycle r0_resp_valid=1, r0_resp_data=32'h0F00_0000.
- Contention: both requesters valid every cycle with resp_ready=1, r0 data=32'h8000_0000 shamt=31, r1 data=32'hFFFF_FFFF shamt=0 -> grants 01,10,01,10 starting with r0 after reset; r0 results = 32'h0000_0001, r1 results = 32'hFFFF_FFFF.
- Backpressure: r0_resp_ready=0 after one result is captured, r0 still valid -> r0_ready stays 0, r0_resp_data holds its value, and r1 is granted every cycle. Raising r0_resp_ready -> r0 is granted the same cycle and resp_valid stays 1 with the new data next cycle.
- Idle: no valid inputs -> grant=00, sh_signal=6'b000000, sh_dataA=0, sh_dataB=0.
- Reset mid-operation: assert rst_n low while r1_resp_valid=1 and a grant to r0 is in progress -> both resp_valid=0 and resp_data=0 immediately. After release with both requesters valid, r0 is granted first.
- Shift amount sweep: r1 data=32'hA5A5_A5A5 with shamt 0..31 streamed with resp_ready=1 -> each result equals data>>shamt one cycle after its acceptance.

Source files
------------

// File: rtl/shift_arbiter.sv
// Round-robin valid/ready arbiter sharing one SRL shifter between
// the EX-stage ALU path and the mul/div unit, with per-requester result slots.
module shift_arbiter #(
  parameter int         WIDTH     = 32,
  parameter logic [5:0] SRL_CODE  = 6'b000010,
  parameter logic [5:0] IDLE_CODE = 6'b000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_data,
  input  logic [4:0]       r0_shamt,
  output logic             r0_resp_valid,
  input  logic             r0_resp_ready,
  output logic [WIDTH-1:0] r0_resp_data,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_data,
  input  logic [4:0]       r1_shamt,
  output logic             r1_resp_valid,
  input  logic             r1_resp_ready,
  output logic [WIDTH-1:0] r1_resp_data,
  output logic [WIDTH-1:0] sh_dataA,
  output logic [WIDTH-1:0] sh_dataB,
  output logic [5:0]       sh_signal,
  input  logic [WIDTH-1:0] sh_dataOut,
  output logic [1:0]       grant
);

  logic free0;
  logic free1;
  logic elig0;
  logic elig1;
  logic prio;

  // A full slot being drained this cycle can be refilled at the same edge
  assign free0 = !r0_resp_valid || r0_resp_ready;
  assign free1 = !r1_resp_valid || r1_resp_ready;
  assign elig0 = rst_n && r0_valid && free0;
  assign elig1 = rst_n && r1_valid && free1;

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      elig0 && elig1:  grant = prio ? 2'b10 : 2'b01;
      elig0 && !elig1: grant = 2'b01;
      !elig0 && elig1: grant = 2'b10;
      default:         grant = 2'b00;
    endcase
  end

  assign r0_ready = grant[0];
  assign r1_ready = grant[1];

  always_comb begin
    sh_dataA  = '0;
    sh_dataB  = '0;
    sh_signal = IDLE_CODE;
    unique case (1'b1)
      grant[0]: begin
        sh_dataA  = r0_data;
        sh_dataB  = {{(WIDTH-5){1'b0}}, r0_shamt};
        sh_signal = SRL_CODE;
      end
      grant[1]: begin
        sh_dataA  = r1_data;
        sh_dataB  = {{(WIDTH-5){1'b0}}, r1_shamt};
        sh_signal = SRL_CODE;
      end
      default: begin
        sh_dataA  = '0;
        sh_dataB  = '0;
        sh_signal = IDLE_CODE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (grant[0]) begin
      prio <= 1'b1;
    end else if (grant[1]) begin
      prio <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_resp_valid <= 1'b0;
      r0_resp_data  <= '0;
    end else if (grant[0]) begin
      r0_resp_valid <= 1'b1;
      r0_resp_data  <= sh_dataOut;
    end else if (r0_resp_ready) begin
      r0_resp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_resp_valid <= 1'b0;
      r1_resp_data  <= '0;
    end else if (grant[1]) begin
      r1_resp_valid <= 1'b1;
      r1_resp_data  <= sh_dataOut;
    end else if (r1_resp_ready) begin
      r1_resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed stimulus, queued expected results,
// and a monitor that checks each result as its requester consumes it.
module tb_shift_arbiter;

  logic        clk;
  logic        rst_n;
  logic        r0_valid;
  logic        r0_ready;
  logic [31:0] r0_data;
  logic [4:0]  r0_shamt;
  logic        r0_resp_valid;
  logic        r0_resp_ready;
  logic [31:0] r0_resp_data;
  logic        r1_valid;
  logic        r1_ready;
  logic [31:0] r1_data;
  logic [4:0]  r1_shamt;
  logic        r1_resp_valid;
  logic        r1_resp_ready;
  logic [31:0] r1_resp_data;
  logic [31:0] sh_dataA;
  logic [31:0] sh_dataB;
  logic [5:0]  sh_signal;
  logic [31:0] sh_dataOut;
  logic [1:0]  grant;

  int tests;
  int fails;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  shift_arbiter dut (
    .clk(clk),
    .rst_n(rst_n),
    .r0_valid(r0_valid),
    .r0_ready(r0_ready),
    .r0_data(r0_data),
    .r0_shamt(r0_shamt),
    .r0_resp_valid(r0_resp_valid),
    .r0_resp_ready(r0_resp_ready),
    .r0_resp_data(r0_resp_data),
    .r1_valid(r1_valid),
    .r1_ready(r1_ready),
    .r1_data(r1_data),
    .r1_shamt(r1_shamt),
    .r1_resp_valid(r1_resp_valid),
    .r1_resp_ready(r1_resp_ready),
    .r1_resp_data(r1_resp_data),
    .sh_dataA(sh_dataA),
    .sh_dataB(sh_dataB),
    .sh_signal(sh_signal),
    .sh_dataOut(sh_dataOut),
    .grant(grant)
  );

  // Combinational SRL datapath the arbiter drives
  assign sh_dataOut = (sh_signal == 6'b000010) ?
                      (sh_dataA >> sh_dataB[4:0]) : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && r0_resp_valid && r0_resp_ready) begin
      if (q0.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL r0_resp_unexpected: got %h expected none",
                 r0_resp_data);
      end else begin
        chk("r0_resp_data", r0_resp_data, q0.pop_front());
      end
    end
    if (rst_n && r1_resp_valid && r1_resp_ready) begin
      if (q1.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL r1_resp_unexpected: got %h expected none",
                 r1_resp_data);
      end else begin
        chk("r1_resp_data", r1_resp_data, q1.pop_front());
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a5;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    r0_valid = 1'b0;
    r0_data = '0;
    r0_shamt = '0;
    r0_resp_ready = 1'b1;
    r1_valid = 1'b0;
    r1_data = '0;
    r1_shamt = '0;
    r1_resp_ready = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_r0_resp_valid", {31'b0, r0_resp_valid}, 32'h0);
    chk("rst_r1_resp_valid", {31'b0, r1_resp_valid}, 32'h0);
    chk("rst_r0_resp_data", r0_resp_data, 32'h0);
    chk("rst_r1_resp_data", r1_resp_data, 32'h0);
    chk("rst_grant", {30'b0, grant}, 32'h0);
    chk("rst_sh_signal", {26'b0, sh_signal}, 32'h0);
    r0_valid = 1'b1;
    #1;
    chk("grant_in_reset", {30'b0, grant}, 32'h0);
    r0_valid = 1'b0;
    nxt();
    rst_n = 1'b1;

    // single request
    r0_valid = 1'b1;
    r0_data = 32'hF000_000F;
    r0_shamt = 5'd4;
    q0.push_back(32'h0F00_0000);
    @(negedge clk);
    chk("single_r0_ready", {31'b0, r0_ready}, 32'h1);
    chk("single_grant", {30'b0, grant}, 32'h1);
    chk("single_sh_dataA", sh_dataA, 32'hF000_000F);
    chk("single_sh_dataB", sh_dataB, 32'h4);
    chk("single_sh_signal", {26'b0, sh_signal}, 32'h2);
    nxt();
    r0_valid = 1'b0;
    @(negedge clk);
    chk("single_resp_valid", {31'b0, r0_resp_valid}, 32'h1);
    chk("idle_grant", {30'b0, grant}, 32'h0);
    chk("idle_sh_signal", {26'b0, sh_signal}, 32'h0);
    chk("idle_sh_dataA", sh_dataA, 32'h0);
    chk("idle_sh_dataB", sh_dataB, 32'h0);
    nxt();

    // contention after a fresh reset
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #2;
    rst_n = 1'b1;
    r0_valid = 1'b1;
    r0_data = 32'h8000_0000;
    r0_shamt = 5'd31;
    r1_valid = 1'b1;
    r1_data = 32'hFFFF_FFFF;
    r1_shamt = 5'd0;
    repeat (2) q0.push_back(32'h0000_0001);
    repeat (2) q1.push_back(32'hFFFF_FFFF);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] eg;
      eg = (k % 2 == 0) ? 32'h1 : 32'h2;
      @(negedge clk);
      chk("contend_grant", {30'b0, grant}, eg);
      nxt();
    end

    // backpressure on r0
    r0_resp_ready = 1'b0;
    r0_data = 32'h0000_FF00;
    r0_shamt = 5'd8;
    q0.push_back(32'h0000_00FF);
    r1_data = 32'h1234_5678;
    r1_shamt = 5'd4;
    @(negedge clk);
    chk("bp_first_grant", {30'b0, grant}, 32'h1);
    nxt();
    r0_data = 32'hF000_0000;
    r0_shamt = 5'd28;
    q0.push_back(32'h0000_000F);
    repeat (3) q1.push_back(32'h0123_4567);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_grant_r1", {30'b0, grant}, 32'h2);
      chk("bp_r0_ready", {31'b0, r0_ready}, 32'h0);
      chk("bp_r0_resp_valid", {31'b0, r0_resp_valid}, 32'h1);
      chk("bp_r0_hold", r0_resp_data, 32'h0000_00FF);
      nxt();
    end
    r1_valid = 1'b0;
    r0_resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_grant", {30'b0, grant}, 32'h1);
    chk("bp_release_ready", {31'b0, r0_ready}, 32'h1);
    nxt();
    r0_valid = 1'b0;
    @(negedge clk);
    chk("bp_refill_valid", {31'b0, r0_resp_valid}, 32'h1);
    chk("bp_refill_data", r0_resp_data, 32'h0000_000F);
    nxt();

    // idle
    @(negedge clk);
    chk("idle2_grant", {30'b0, grant}, 32'h0);
    chk("idle2_sh_dataA", sh_dataA, 32'h0);
    chk("idle2_sh_dataB", sh_dataB, 32'h0);
    chk("idle2_sh_signal", {26'b0, sh_signal}, 32'h0);
    nxt();

    // reset while r1 holds a result and r0 is being granted
    r1_resp_ready = 1'b0;
    r1_valid = 1'b1;
    r1_data = 32'h0000_0080;
    r1_shamt = 5'd7;
    @(negedge clk);
    chk("mid_r1_grant", {30'b0, grant}, 32'h2);
    nxt();
    r1_valid = 1'b0;
    r0_valid = 1'b1;
    r0_data = 32'h0000_0F00;
    r0_shamt = 5'd8;
    @(negedge clk);
    chk("mid_r1_resp_valid", {31'b0, r1_resp_valid}, 32'h1);
    chk("mid_r1_resp_data", r1_resp_data, 32'h0000_0001);
    chk("mid_r0_grant", {30'b0, grant}, 32'h1);
    #2;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    chk("mid_rst_r0_valid", {31'b0, r0_resp_valid}, 32'h0);
    chk("mid_rst_r1_valid", {31'b0, r1_resp_valid}, 32'h0);
    chk("mid_rst_r0_data", r0_resp_data, 32'h0);
    chk("mid_rst_r1_data", r1_resp_data, 32'h0);
    chk("mid_rst_grant", {30'b0, grant}, 32'h0);
    nxt();
    rst_n = 1'b1;
    r1_resp_ready = 1'b1;
    r1_valid = 1'b1;
    r1_data = 32'h0000_0F00;
    r1_shamt = 5'd4;
    q0.push_back(32'h0000_000F);
    @(negedge clk);
    chk("post_rst_grant_r0", {30'b0, grant}, 32'h1);
    nxt();
    r0_valid = 1'b0;
    q1.push_back(32'h0000_00F0);
    @(negedge clk);
    chk("post_rst_grant_r1", {30'b0, grant}, 32'h2);
    nxt();

    // shift amount sweep on r1
    a5 = 32'hA5A5_A5A5;
    r1_data = a5;
    for (int i = 0; i < 32; i++) begin
      r1_shamt = i[4:0];
      q1.push_back(a5 >> i);
      @(negedge clk);
      chk("sweep_grant", {30'b0, grant}, 32'h2);
      nxt();
    end
    r1_valid = 1'b0;
    repeat (3) nxt();
    chk("q0_drained", q0.size(), 32'h0);
    chk("q1_drained", q1.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
